demux_1to3_router: RTL and testbench
====================================

DEMUX_1TO3_ROUTER -- requirements
Module: demux_1to3_router

Interface
REQ-001 WORD_LENGTH, default 32, bit-width of the data path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on rising clk edge; asserted when 0).
REQ-004 Selector  input  2  destination channel for the current input word.
REQ-005 In_Valid  input  1  input word and Selector are valid this cycle.
REQ-006 In_Ready  output  1  block accepts the input word this cycle.
REQ-007 In_Data  input  WORD_LENGTH  input word.
REQ-008 Out_Valid0/1/2  output  1 each  holding register of channel n contains a word.
REQ-009 Out_Ready0/1/2  input  1 each  downstream n consumes the word this cycle.
REQ-010 Out_Data0/1/2  output  WORD_LENGTH each  word held for channel n.
REQ-011 Drop_Count  output  8  count of discarded Selector==3 words (see Configuration).

Function
REQ-012 Each channel n SHALL have one holding register (data + valid flag); Out_Data n and Out_Valid n SHALL be driven directly from it.
REQ-013 Input transfer = In_Valid & In_Ready; output transfer n = Out_Valid n & Out_Ready n.
REQ-014 In_Ready SHALL equal (!Out_Valid s | Out_Ready s) for s = selected channel; combinational, independent of In_Valid.
REQ-015 Latency: a word accepted in cycle k SHALL appear on Out_Data s with Out_Valid s=1 from cycle k+1.
REQ-016 Simultaneous output transfer and input transfer on the same channel SHALL replace the held word, Out_Valid stays 1; full throughput of one word per cycle per channel.
REQ-017 Output transfer with no input transfer on that channel SHALL clear Out_Valid n next cycle.
REQ-018 While Out_Valid n=1 and Out_Ready n=0, Out_Data n SHALL remain stable.
REQ-019 Channels SHALL be independent: a stalled channel SHALL NOT block inputs selecting another channel.
REQ-020 Only the selected channel SHALL be loaded; unselected registers keep their contents.
REQ-021 Out_Data n SHALL NOT change when no input transfer targets channel n.
REQ-022 Selector==3 handling SHALL follow Configuration.
REQ-023 Selector and In_Data are don't-care when In_Valid=0; no state change results.

Reset
REQ-024 With reset=0 at a rising edge: Out_Valid0/1/2=0, Out_Data0/1/2=0, Drop_Count=0.
REQ-025 Reset mid-operation SHALL discard all held words; no output transfer occurs in the reset cycle.
REQ-026 In_Ready during reset follows REQ-014 from the reset register values; inputs presented during reset SHALL be ignored.

Configuration
REQ-027 Macro DEMUX_ILLEGAL_DROP_EN.
REQ-028 Defined: Selector==3 -> In_Ready=1, the word is discarded, Drop_Count increments by 1, saturating at 255.
REQ-029 Not defined: Selector==3 SHALL route to channel 0 (same as Selector==0); Drop_Count tied to 0.

Verification
REQ-030 Reset, then In_Valid=1, Selector=1, In_Data=0xA5A5A5A5, Out_Ready1=1 -> next cycle Out_Valid1=1, Out_Data1=0xA5A5A5A5; Out_Valid0/2=0.
REQ-031 Out_Ready2=0, send 0x11 then 0x22 to channel 2 -> first accepted, In_Ready=0 for second, Out_Data2 holds 0x11; raise Out_Ready2 -> 0x22 accepted same cycle, Out_Data2=0x22 next cycle.
REQ-032 Channel 0 stalled full; send 0x33 to channel 1 -> accepted, Out_Data1=0x33 next cycle, channel 0 unchanged.
REQ-033 Back-to-back 0x1..0x8 to channel 0 with Out_Ready0=1 -> one word per cycle out, in order, no gaps.
REQ-034 Selector=3, In_Data=0x77, 300 transfers -> with DEMUX_ILLEGAL_DROP_EN: no Out_Valid, Drop_Count=255; without: Out_Data0=0x77, Drop_Count=0.
REQ-035 Hold words in all channels, assert reset=0 one cycle -> all Out_Valid=0, all Out_Data=0, Drop_Count=0.

Source files
------------

// File: rtl/demux_1to3_router_if.sv
// Handshake bundle for the 1-to-3 router: one input stream, three output channels.
interface demux_1to3_router_if #(parameter int WORD_LENGTH = 32);
  logic [1:0]             Selector;
  logic                   In_Valid;
  logic                   In_Ready;
  logic [WORD_LENGTH-1:0] In_Data;
  logic                   Out_Valid0, Out_Valid1, Out_Valid2;
  logic                   Out_Ready0, Out_Ready1, Out_Ready2;
  logic [WORD_LENGTH-1:0] Out_Data0, Out_Data1, Out_Data2;
  logic [7:0]             Drop_Count;

  modport slave (
    input  Selector, In_Valid, In_Data, Out_Ready0, Out_Ready1, Out_Ready2,
    output In_Ready, Out_Valid0, Out_Valid1, Out_Valid2,
           Out_Data0, Out_Data1, Out_Data2, Drop_Count
  );

  modport master (
    output Selector, In_Valid, In_Data, Out_Ready0, Out_Ready1, Out_Ready2,
    input  In_Ready, Out_Valid0, Out_Valid1, Out_Valid2,
           Out_Data0, Out_Data1, Out_Data2, Drop_Count
  );
endinterface

// File: rtl/demux_1to3_router.sv
// 1-to-3 demux with one holding register per channel and full per-channel throughput.
// Define DEMUX_ILLEGAL_DROP_EN to discard Selector==3 words and count them; otherwise they go to channel 0.
module demux_1to3_router #(
  parameter int WORD_LENGTH = 32
) (
  input logic                clk,
  input logic                reset,
  demux_1to3_router_if.slave bus
);

  logic [2:0]                  vld_q, vld_d;
  logic [2:0][WORD_LENGTH-1:0] data_q, data_d;
  logic [2:0]                  rdy, free, load;
  logic [1:0]                  ch;
  logic                        illegal;
  logic                        sel_free;
  logic                        in_xfer;

`ifdef DEMUX_ILLEGAL_DROP_EN
  assign illegal = (bus.Selector == 2'd3);
  assign ch      = bus.Selector;
`else
  assign illegal = 1'b0;
  assign ch      = (bus.Selector == 2'd3) ? 2'd0 : bus.Selector;
`endif

  assign rdy  = {bus.Out_Ready2, bus.Out_Ready1, bus.Out_Ready0};
  assign free = ~vld_q | rdy;

  // ch==3 only survives into this case when dropping is enabled; a dropped word is always accepted.
  always_comb begin
    sel_free = 1'b1;
    case (ch)
      2'd0:    sel_free = free[0];
      2'd1:    sel_free = free[1];
      2'd2:    sel_free = free[2];
      default: sel_free = 1'b1;
    endcase
  end

  assign bus.In_Ready = sel_free;
  assign in_xfer      = bus.In_Valid & sel_free;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    load   = '0;
    for (int n = 0; n < 3; n++) begin
      load[n] = in_xfer & ~illegal & (ch == n[1:0]);
      if (load[n]) begin
        vld_d[n]  = 1'b1;
        data_d[n] = bus.In_Data;
      end else if (vld_q[n] & rdy[n]) begin
        vld_d[n]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign bus.Out_Valid0 = vld_q[0];
  assign bus.Out_Valid1 = vld_q[1];
  assign bus.Out_Valid2 = vld_q[2];
  assign bus.Out_Data0  = data_q[0];
  assign bus.Out_Data1  = data_q[1];
  assign bus.Out_Data2  = data_q[2];

`ifdef DEMUX_ILLEGAL_DROP_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (in_xfer && illegal && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign bus.Drop_Count = drop_q;
`else
  assign bus.Drop_Count = '0;
`endif

endmodule

// File: tb/tb_demux_1to3_router.sv
// Self-checking bench for demux_1to3_router: directed scenarios then random traffic against a channel model.
module tb_demux_1to3_router;

`ifdef DEMUX_ILLEGAL_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk;
  logic reset;

  demux_1to3_router_if #(.WORD_LENGTH(32)) bus ();

  demux_1to3_router #(.WORD_LENGTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference: what each channel currently holds, and the drop tally.
  bit          mv   [3];
  logic [31:0] md   [3];
  int          mdrop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_vld(input int n);
    case (n)
      0:       return bus.Out_Valid0;
      1:       return bus.Out_Valid1;
      default: return bus.Out_Valid2;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int n);
    case (n)
      0:       return bus.Out_Data0;
      1:       return bus.Out_Data1;
      default: return bus.Out_Data2;
    endcase
  endfunction

  // One clock: drive, check the ready, advance the model at the edge, check all outputs.
  task automatic step(input logic r, input logic [1:0] sel, input logic v,
                      input logic [31:0] d, input logic [2:0] ordy);
    int   c;
    bit   ill, exp_rdy, xfer;
    reset          = r;
    bus.Selector   = sel;
    bus.In_Valid   = v;
    bus.In_Data    = d;
    bus.Out_Ready0 = ordy[0];
    bus.Out_Ready1 = ordy[1];
    bus.Out_Ready2 = ordy[2];
    #2;
    ill     = DROP && (sel == 2'd3);
    c       = (sel == 2'd3) ? 0 : int'(sel);
    exp_rdy = ill ? 1'b1 : (!mv[c] || ordy[c]);
    check("in_ready", {31'd0, bus.In_Ready}, {31'd0, exp_rdy});
    @(posedge clk);
    xfer = v && exp_rdy;
    if (!r) begin
      for (int n = 0; n < 3; n++) begin mv[n] = 0; md[n] = '0; end
      mdrop = 0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (xfer && !ill && c == n) begin mv[n] = 1; md[n] = d; end
        else if (mv[n] && ordy[n]) mv[n] = 0;
      end
      if (xfer && ill && mdrop < 255) mdrop++;
    end
    #1;
    for (int n = 0; n < 3; n++) begin
      check($sformatf("out_valid%0d", n), {31'd0, get_vld(n)}, {31'd0, mv[n]});
      check($sformatf("out_data%0d", n), get_data(n), md[n]);
    end
    check("drop_count", {24'd0, bus.Drop_Count}, 32'(mdrop));
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin mv[n] = 0; md[n] = '0; end
    mdrop = 0;
    // Bring registers out of X before any model comparison.
    reset = 1'b0; bus.Selector = '0; bus.In_Valid = 1'b0; bus.In_Data = '0;
    bus.Out_Ready0 = 1'b0; bus.Out_Ready1 = 1'b0; bus.Out_Ready2 = 1'b0;
    @(posedge clk); #1;

    // Inputs during reset are ignored.
    step(1'b0, 2'd1, 1'b1, 32'hDEAD_BEEF, 3'b111);
    check("rst_valid1", {31'd0, bus.Out_Valid1}, 32'd0);

    // Basic route to channel 1.
    step(1'b1, 2'd1, 1'b1, 32'hA5A5_A5A5, 3'b010);
    check("basic_data1", bus.Out_Data1, 32'hA5A5_A5A5);
    check("basic_valid0", {31'd0, bus.Out_Valid0}, 32'd0);
    step(1'b1, 2'd0, 1'b0, 32'h0, 3'b111);

    // Backpressure on channel 2.
    step(1'b1, 2'd2, 1'b1, 32'h11, 3'b000);
    step(1'b1, 2'd2, 1'b1, 32'h22, 3'b000);
    check("stall_hold2", bus.Out_Data2, 32'h11);
    step(1'b1, 2'd2, 1'b1, 32'h22, 3'b100);
    check("stall_replace2", bus.Out_Data2, 32'h22);
    step(1'b1, 2'd0, 1'b0, 32'h0, 3'b111);

    // Stalled channel 0 does not block channel 1.
    step(1'b1, 2'd0, 1'b1, 32'h44, 3'b000);
    step(1'b1, 2'd1, 1'b1, 32'h33, 3'b000);
    check("indep_data1", bus.Out_Data1, 32'h33);
    check("indep_data0", bus.Out_Data0, 32'h44);
    step(1'b1, 2'd0, 1'b0, 32'h0, 3'b111);

    // Back-to-back stream on channel 0.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'd0, 1'b1, 32'(i), 3'b001);
      check("stream_data0", bus.Out_Data0, 32'(i));
    end
    step(1'b1, 2'd0, 1'b0, 32'h0, 3'b111);

    // Selector==3 traffic.
    repeat (300) step(1'b1, 2'd3, 1'b1, 32'h77, 3'b001);
    check("sel3_drop", {24'd0, bus.Drop_Count}, DROP ? 32'd255 : 32'd0);
    check("sel3_data0", bus.Out_Data0, DROP ? 32'h8 : 32'h77);

    // Reset with all channels holding.
    step(1'b1, 2'd0, 1'b1, 32'hC0, 3'b000);
    step(1'b1, 2'd1, 1'b1, 32'hC1, 3'b000);
    step(1'b1, 2'd2, 1'b1, 32'hC2, 3'b000);
    step(1'b0, 2'd2, 1'b1, 32'hC3, 3'b000);
    check("midrst_data2", bus.Out_Data2, 32'd0);

    // Random traffic.
    repeat (400) begin
      step(($urandom % 40) != 0, 2'($urandom), 1'($urandom), $urandom, 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
